// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: shares one registered 16-bit ALU between two requesters.
// Round-robin grant, one operation in flight, response on a valid/ready port.
//
// Handshake semantics (both command ports and the response port):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   The producer holds valid and payload stable until that edge. reqN_ready
//   is combinational and is only raised in IDLE for the granted requester.
//   rsp_valid and rsp_* are registered and held until rsp_ready.
module alu_req_arbiter #(
   parameter int W       = 16,
   parameter int ALU_LAT = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [3:0]   req0_fun,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [3:0]   req1_fun,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   output logic [3:0]   alu_fun,
   input  logic [W-1:0] alu_out,
   input  logic [3:0]   alu_flags,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_id,
   output logic [W-1:0] rsp_data,
   output logic [3:0]   rsp_flags,
   output logic         rsp_err,
   output logic [1:0]   state_dbg,
   output logic         rr_ptr_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] FUN_DIV = 4'b0011;
   localparam logic [3:0] FUN_NOP = 4'b1111;
   localparam int         CW      = $clog2(ALU_LAT + 1);

   state_t         state;
   logic           rr_ptr;
   logic [CW-1:0]  cnt;

   logic           grant_valid;
   logic           grant_id;
   logic [3:0]     sel_fun;
   logic [W-1:0]   sel_a;
   logic [W-1:0]   sel_b;
   logic           div_zero;
   logic           accept;

   // Pick the requester to serve: the only valid one, or rr_ptr on a tie.
   always_comb begin
      grant_valid = req0_valid | req1_valid;
      grant_id    = 1'b0;
      if (req0_valid && req1_valid) begin
         grant_id = rr_ptr;
      end else if (req1_valid) begin
         grant_id = 1'b1;
      end
   end

   assign req0_ready = (state == IDLE) && grant_valid && !grant_id;
   assign req1_ready = (state == IDLE) && grant_valid &&  grant_id;
   assign accept     = (state == IDLE) && grant_valid;

   assign sel_fun  = grant_id ? req1_fun : req0_fun;
   assign sel_a    = grant_id ? req1_a   : req0_a;
   assign sel_b    = grant_id ? req1_b   : req0_b;
   // Divide by zero never reaches the ALU; it is answered directly with an error.
   assign div_zero = (sel_fun == FUN_DIV) && (sel_b == '0);

   assign state_dbg  = state;
   assign rr_ptr_dbg = rr_ptr;

   // Control FSM: accept in IDLE, wait out ALU latency, hold response until taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= 1'b0;
         cnt       <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_fun   <= FUN_NOP;
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_data  <= '0;
         rsp_flags <= '0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  rsp_id <= grant_id;
                  alu_a  <= sel_a;
                  alu_b  <= sel_b;
                  cnt    <= CW'(ALU_LAT);
                  if (div_zero) begin
                     // Keep the ALU on NOP so it never sees the illegal divide.
                     alu_fun   <= FUN_NOP;
                     rsp_data  <= '0;
                     rsp_flags <= '0;
                     rsp_err   <= 1'b1;
                     rsp_valid <= 1'b1;
                     state     <= RESP;
                  end else begin
                     alu_fun <= sel_fun;
                     state   <= WAIT;
                  end
               end
            end
            WAIT: begin
               // cnt runs ALU_LAT..0, giving ALU_LAT+1 cycles in WAIT.
               if (cnt == '0) begin
                  rsp_data  <= alu_out;
                  rsp_flags <= alu_flags;
                  rsp_err   <= 1'b0;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  rr_ptr    <= ~rsp_id;
                  alu_fun   <= FUN_NOP;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Testbench for alu_req_arbiter: directed commands from two requesters, a
// behavioural registered ALU, and a scoreboard fed at command acceptance.
module tb_alu_req_arbiter;

   localparam int W       = 16;
   localparam int ALU_LAT = 1;
   localparam int EW      = W + 10;

   localparam logic [3:0] F_ADD = 4'b0000, F_SUB = 4'b0001, F_MUL = 4'b0010,
                          F_DIV = 4'b0011, F_AND = 4'b0100, F_XOR = 4'b1000,
                          F_EQ  = 4'b1010, F_GT  = 4'b1011, F_LT  = 4'b1100,
                          F_SHR = 4'b1101, F_SHL = 4'b1110;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic         req0_valid = 1'b0, req1_valid = 1'b0;
   logic         req0_ready, req1_ready;
   logic [3:0]   req0_fun = '0, req1_fun = '0;
   logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic [W-1:0] alu_a, alu_b;
   logic [3:0]   alu_fun;
   logic [W-1:0] alu_out = '0;
   logic [3:0]   alu_flags = '0;
   logic         rsp_valid;
   logic         rsp_ready = 1'b1;
   logic         rsp_id;
   logic [W-1:0] rsp_data;
   logic [3:0]   rsp_flags;
   logic         rsp_err;
   logic [1:0]   state_dbg;
   logic         rr_ptr_dbg;

   alu_req_arbiter #(.W(W), .ALU_LAT(ALU_LAT)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_fun(req0_fun),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_fun(req1_fun),
      .req1_a(req1_a), .req1_b(req1_b),
      .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
      .alu_out(alu_out), .alu_flags(alu_flags),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
      .state_dbg(state_dbg), .rr_ptr_dbg(rr_ptr_dbg)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int acc_cyc = 0;
   int div0_seen = 0;
   logic          prev_valid = 1'b0;
   logic [EW-1:0] exp_q[$];
   logic          grant_log[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural ALU with one registered stage; flags {arith,logic,cmp,shift}.
   always @(posedge clk) begin
      if (alu_fun == F_DIV && alu_b == '0) div0_seen <= div0_seen + 1;
      case (alu_fun)
         4'b0000: begin alu_out <= alu_a + alu_b; alu_flags <= 4'b1000; end
         4'b0001: begin alu_out <= alu_a - alu_b; alu_flags <= 4'b1000; end
         4'b0010: begin alu_out <= W'($signed(alu_a) * $signed(alu_b)); alu_flags <= 4'b1000; end
         4'b0011: begin
            alu_out   <= (alu_b == '0) ? '0 : W'($signed(alu_a) / $signed(alu_b));
            alu_flags <= 4'b1000;
         end
         4'b0100: begin alu_out <= alu_a & alu_b;    alu_flags <= 4'b0100; end
         4'b0101: begin alu_out <= alu_a | alu_b;    alu_flags <= 4'b0100; end
         4'b0110: begin alu_out <= ~(alu_a & alu_b); alu_flags <= 4'b0100; end
         4'b0111: begin alu_out <= ~(alu_a | alu_b); alu_flags <= 4'b0100; end
         4'b1000: begin alu_out <= alu_a ^ alu_b;    alu_flags <= 4'b0100; end
         4'b1001: begin alu_out <= ~(alu_a ^ alu_b); alu_flags <= 4'b0100; end
         4'b1010: begin alu_out <= (alu_a == alu_b) ? W'(1) : '0; alu_flags <= 4'b0010; end
         4'b1011: begin alu_out <= ($signed(alu_a) > $signed(alu_b)) ? W'(2) : '0; alu_flags <= 4'b0010; end
         4'b1100: begin alu_out <= ($signed(alu_a) < $signed(alu_b)) ? W'(3) : '0; alu_flags <= 4'b0010; end
         4'b1101: begin alu_out <= alu_a >> 1; alu_flags <= 4'b0001; end
         4'b1110: begin alu_out <= alu_a << 1; alu_flags <= 4'b0001; end
         default: begin alu_out <= '0; alu_flags <= 4'b0000; end
      endcase
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: samples on the falling edge, pops on response handshake.
   logic [EW-1:0] head;
   always @(negedge clk) begin
      if (rst) begin
         prev_valid = 1'b0;
      end else begin
         if (state_dbg != 2'd0) chk("no_ready_when_busy", {req0_ready, req1_ready}, 0);
         if (req0_valid && req0_ready) begin acc_cyc = cyc; grant_log.push_back(1'b0); end
         if (req1_valid && req1_ready) begin acc_cyc = cyc; grant_log.push_back(1'b1); end
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rsp got id=%0d data=%0h required no response", rsp_id, rsp_data);
            end else begin
               head = exp_q[0];
               if (!prev_valid) chk("rsp_latency", cyc - acc_cyc, {28'd0, head[3:0]});
               chk("rsp_data",  {16'd0, rsp_data},  {16'd0, head[W+3:4]});
               chk("rsp_flags", {28'd0, rsp_flags}, {28'd0, head[W+7:W+4]});
               chk("rsp_err",   {31'd0, rsp_err},   {31'd0, head[W+8]});
               chk("rsp_id",    {31'd0, rsp_id},    {31'd0, head[W+9]});
               if (rsp_ready) void'(exp_q.pop_front());
            end
         end
         prev_valid = rsp_valid;
      end
   end

   // Driver: present one command, wait (bounded) for ready, record expectation at accept.
   task automatic send(input bit id, input logic [3:0] fun, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] ed, input logic [3:0] ef,
                       input bit ee, input bit push);
      bit got = 1'b0;
      if (id) begin req1_valid = 1'b1; req1_fun = fun; req1_a = a; req1_b = b; end
      else    begin req0_valid = 1'b1; req0_fun = fun; req0_a = a; req0_b = b; end
      for (int n = 0; n < 100 && !got; n++) begin
         @(negedge clk);
         if (id ? req1_ready : req0_ready) got = 1'b1;
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL grant_timeout id=%0d got no ready required ready", id);
      end else if (push) begin
         exp_q.push_back({id, ee, ef, ed, (ee ? 4'd1 : 4'(2 + ALU_LAT))});
      end
      @(posedge clk);
      #1;
      if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit done = 1'b0;
      for (int n = 0; n < 200 && !done; n++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && state_dbg == 2'd0) done = 1'b1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout got %0d pending required 0", exp_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic chk_grants(input logic exp_g[$]);
      chk("grant_count", grant_log.size(), exp_g.size());
      for (int i = 0; i < exp_g.size() && i < grant_log.size(); i++)
         chk("grant_order", {31'd0, grant_log[i]}, {31'd0, exp_g[i]});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic exp_g[$];
      bit seen;

      // reset state
      do_reset();
      @(negedge clk);
      chk("reset_state",     {30'd0, state_dbg}, 0);
      chk("reset_rr_ptr",    {31'd0, rr_ptr_dbg}, 0);
      chk("reset_rsp_valid", {31'd0, rsp_valid}, 0);
      chk("reset_rsp_data",  {16'd0, rsp_data}, 0);
      chk("reset_rsp_misc",  {26'd0, rsp_flags, rsp_err, rsp_id}, 0);
      chk("reset_alu_ab",    {alu_a, alu_b}, 0);
      chk("reset_alu_fun",   {28'd0, alu_fun}, 32'hF);
      chk("reset_ready",     {30'd0, req0_ready, req1_ready}, 0);
      @(posedge clk);
      #1;

      // single ADD from requester 0
      send(1'b0, F_ADD, 16'd1, 16'd3, 16'd4, 4'b1000, 1'b0, 1'b1);
      wait_idle();

      // both valid together after reset: grant 0 then 1
      do_reset();
      grant_log.delete();
      fork
         send(1'b0, F_SUB, 16'd10, 16'd3, 16'd7, 4'b1000, 1'b0, 1'b1);
         send(1'b1, F_MUL, 16'd10, 16'hFFFD, 16'hFFE2, 4'b1000, 1'b0, 1'b1);
      join
      wait_idle();
      exp_g = '{1'b0, 1'b1};
      chk_grants(exp_g);

      // divide by zero from requester 1: immediate error response
      send(1'b1, F_DIV, 16'd12, 16'd0, 16'd0, 4'b0000, 1'b1, 1'b1);
      wait_idle();

      // back-pressure: response held 5 cycles, no command accepted meanwhile
      rsp_ready = 1'b0;
      send(1'b0, F_GT, 16'd15, 16'd13, 16'd2, 4'b0010, 1'b0, 1'b1);
      req1_valid = 1'b1; req1_fun = F_AND; req1_a = 16'd12; req1_b = 16'd10;
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      chk("bp_rsp_seen", {31'd0, seen}, 1);
      for (int n = 0; n < 5; n++) begin
         chk("bp_hold_valid", {31'd0, rsp_valid}, 1);
         chk("bp_hold_data",  {16'd0, rsp_data}, 2);
         chk("bp_hold_flags", {28'd0, rsp_flags}, 32'h2);
         chk("bp_no_ready",   {30'd0, req0_ready, req1_ready}, 0);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      req1_valid = 1'b0;
      wait_idle();

      // reset during WAIT of XOR: response discarded
      send(1'b0, F_XOR, 16'd15, 16'd10, 16'd5, 4'b0100, 1'b0, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_rsp_valid", {31'd0, rsp_valid}, 0);
      chk("midrst_alu_fun",   {28'd0, alu_fun}, 32'hF);
      chk("midrst_rr_ptr",    {31'd0, rr_ptr_dbg}, 0);
      chk("midrst_state",     {30'd0, state_dbg}, 0);
      repeat (10) @(negedge clk);
      @(posedge clk);
      #1;

      // fairness: both requesters continuously valid for 6 operations
      grant_log.delete();
      fork
         begin
            send(1'b0, F_SHR, 16'd12, 16'd1, 16'd6,  4'b0001, 1'b0, 1'b1);
            send(1'b0, F_DIV, 16'd12, 16'd5, 16'd2,  4'b1000, 1'b0, 1'b1);
            send(1'b0, F_SHL, 16'd12, 16'd1, 16'd24, 4'b0001, 1'b0, 1'b1);
         end
         begin
            send(1'b1, F_LT,  16'd12, 16'd13, 16'd3, 4'b0010, 1'b0, 1'b1);
            send(1'b1, F_AND, 16'd12, 16'd10, 16'd8, 4'b0100, 1'b0, 1'b1);
            send(1'b1, F_EQ,  16'd5,  16'd5,  16'd1, 4'b0010, 1'b0, 1'b1);
         end
      join
      wait_idle();
      exp_g = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      chk_grants(exp_g);

      chk("alu_never_div0", div0_seen, 0);
      chk("queue_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
